axis_frame_capture: RTL
=======================

Name: axis_frame_capture

Overview:
AXI-Stream slave sink that captures one frame of N_POINT complex samples ({real, imag}) from an AXIS master, e.g. the FFT output or the test stimulus source.
- Checks frame alignment against tlast.
- Holds the completed frame in a buffer with a registered random-access read port, for checkers and debug readout.
- Frames are released explicitly, giving frame-level back-pressure on the stream.

Parameters:
NB_INPUT, 8, bits per real/imag component
NB_COUNT, 4, sample index / address width (2^NB_COUNT >= N_POINT)
N_POINT, 16, samples per frame
NB_FRAMES, 8, width of good-frame counter

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
s_axis_data_tvalid  in  1  AXIS slave valid
s_axis_data_tdata  in  2*NB_INPUT  {real[2*NB_INPUT-1:NB_INPUT], imag[NB_INPUT-1:0]}
s_axis_data_tlast  in  1  last sample of frame
s_axis_data_tready  out  1  AXIS slave ready
i_release  in  1  pulse: host done reading, re-arm capture
i_clr_err  in  1  pulse: clear sticky error flags
i_rd_en  in  1  read strobe
i_rd_addr  in  NB_COUNT  read sample index
o_rd_data  out  2*NB_INPUT  read data, valid 1 cycle after i_rd_en
o_frame_ready  out  1  complete, aligned frame held in buffer
o_err_early_last  out  1  sticky: tlast seen before index N_POINT-1
o_err_missing_last  out  1  sticky: index N_POINT-1 accepted without tlast
o_frame_count  out  NB_FRAMES  good frames captured, wraps

Behaviour:
- Beat accepted iff tvalid && tready. tready is combinational from state only, never from tvalid.
- States:
  - CAPTURE: tready=1.
  - HOLD: tready=0, o_frame_ready=1.
  - SKIP: tready=1, beats discarded.
- Reset → CAPTURE, write index 0, all flags 0, o_frame_count 0, o_rd_data 0, o_frame_ready 0. Buffer contents are not reset.
- CAPTURE, accepted beat:
  - Write tdata to buffer[index].
  - index < N_POINT-1, tlast=0 → index+1.
  - index < N_POINT-1, tlast=1 → set o_err_early_last; index ← 0; stay CAPTURE. The partial frame is discarded; the next beat starts a new frame at index 0.
  - index = N_POINT-1, tlast=1 → HOLD; index ← 0; o_frame_count+1 (mod 2^NB_FRAMES). o_frame_ready=1 from the next cycle.
  - index = N_POINT-1, tlast=0 → set o_err_missing_last; index ← 0; → SKIP.
- SKIP: accept and drop beats, no buffer writes. On an accepted beat with tlast → CAPTURE, index 0.
- HOLD:
  - i_release → CAPTURE next cycle; tready=1 and o_frame_ready=0 from that cycle.
  - i_release in CAPTURE or SKIP is ignored.
- Read port:
  - i_rd_en → o_rd_data ← buffer[i_rd_addr] on the next edge; o_rd_data holds otherwise.
  - Reads are allowed in any state. Only HOLD guarantees a coherent frame.
  - Same-cycle write and read of one address returns the old data.
  - i_rd_addr >= N_POINT returns undefined data with no side effects.
- Sticky errors:
  - Set by event, cleared by i_clr_err.
  - Set wins over clear in the same cycle.
- Reset mid-frame: partial frame is lost, state returns to CAPTURE, index 0.
- Throughput: one beat per cycle in CAPTURE/SKIP. Latency from last beat to o_frame_ready is 1 cycle.

Decomposition:
- Shared package fft_axis_pkg: state encodings (ST_CAPTURE, ST_HOLD, ST_SKIP), complex-sample field slicing constants, common with other AXIS stream blocks.
- Sub-module frame_buffer_ram: simple dual-port RAM, N_POINT x 2*NB_INPUT, synchronous write, registered read with enable.
- Control FSM, index counter and flags remain in the top module.

Test Plan:
- Back-to-back 16 beats, tdata = {k, ~k} for k=0..15, tlast on beat 15 → tready drops the cycle after beat 15; o_frame_ready=1; o_frame_count=1; reading addr 5 returns 0x05FA one cycle later.
- tvalid toggled 50% random, same frame → identical buffer contents; capture completes only after 16 accepted beats.
- tlast on beat 7, then a full 16-beat frame → o_err_early_last=1; frame held equals the second frame; count=1.
- 20 beats with tlast only on beat 19, then a valid frame → o_err_missing_last=1 after beat 15; beats 16..19 dropped; the next frame is captured correctly.
- In HOLD, keep tvalid=1 with new data, then pulse i_release → no writes during HOLD; tready=1 the cycle after release; 256+1 frames → o_frame_count wraps to 1.
- Assert i_rst at beat 9 → tready=1, o_frame_ready=0, count=0; the subsequent 16-beat frame is captured from index 0.

Source files
------------

// File: rtl/fft_axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_axis_pkg
// Description : State encodings and complex-sample layout shared by the AXIS
//               stream blocks of the FFT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_axis_pkg;

    localparam int NB_STATE = 2;

    localparam logic [NB_STATE-1:0] ST_CAPTURE = 2'd0;
    localparam logic [NB_STATE-1:0] ST_HOLD    = 2'd1;
    localparam logic [NB_STATE-1:0] ST_SKIP    = 2'd2;

    // A complex sample is {real, imag}, each component NB_INPUT bits wide.
    localparam int CPLX_PARTS  = 2;
    localparam int CPLX_IM_LSB = 0;

    function automatic int cplx_re_lsb(input int nb_input);
        return nb_input;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_ram
// Description : Simple dual-port RAM, synchronous write, registered read with
//               enable. A read of the address being written returns old data.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_ram #(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 4,
    parameter int DEPTH   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam logic [NB_ADDR:0] c_depth = (NB_ADDR+1)'(DEPTH);

    logic [NB_DATA-1:0] mem_q [DEPTH];
    logic [NB_DATA-1:0] rd_data_q;

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && ({1'b0, i_wr_addr} < c_depth)) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (i_rd_en && ({1'b0, i_rd_addr} < c_depth)) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axis_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : axis_frame_capture
// Description : AXIS sink capturing one N_POINT complex frame, checking tlast
//               alignment and holding the frame until explicitly released.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_capture
    import fft_axis_pkg::*;
#(
    parameter int NB_INPUT  = 8,
    parameter int NB_COUNT  = 4,
    parameter int N_POINT   = 16,
    parameter int NB_FRAMES = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           s_axis_data_tvalid,
    input  logic [CPLX_PARTS*NB_INPUT-1:0] s_axis_data_tdata,
    input  logic                           s_axis_data_tlast,
    output logic                           s_axis_data_tready,
    input  logic                           i_release,
    input  logic                           i_clr_err,
    input  logic                           i_rd_en,
    input  logic [NB_COUNT-1:0]            i_rd_addr,
    output logic [CPLX_PARTS*NB_INPUT-1:0] o_rd_data,
    output logic                           o_frame_ready,
    output logic                           o_err_early_last,
    output logic                           o_err_missing_last,
    output logic [NB_FRAMES-1:0]           o_frame_count
);

    localparam logic [NB_COUNT-1:0] c_idx_last = NB_COUNT'(N_POINT - 1);

    logic [NB_STATE-1:0]  state_q, state_d;
    logic [NB_COUNT-1:0]  idx_q, idx_d;
    logic [NB_FRAMES-1:0] cnt_q, cnt_d;
    logic                 early_q, early_d;
    logic                 miss_q, miss_d;

    logic w_accept;
    logic w_wr_en;
    logic w_set_early;
    logic w_set_miss;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_CAPTURE;
            idx_q   <= '0;
            cnt_q   <= '0;
            early_q <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            early_q <= early_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        w_set_early = 1'b0;
        w_set_miss  = 1'b0;
        case (state_q)
            ST_CAPTURE: begin
                if (w_accept) begin
                    if (idx_q == c_idx_last) begin
                        idx_d = '0;
                        if (s_axis_data_tlast) begin
                            state_d = ST_HOLD;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            state_d    = ST_SKIP;
                            w_set_miss = 1'b1;
                        end
                    end else if (s_axis_data_tlast) begin
                        // Short frame: drop it and realign on the next beat.
                        idx_d       = '0;
                        w_set_early = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (i_release) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_SKIP: begin
                if (w_accept && s_axis_data_tlast) begin
                    state_d = ST_CAPTURE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CAPTURE;
                idx_d   = '0;
            end
        endcase
        // A new error event takes priority over a simultaneous clear.
        early_d = w_set_early | (early_q & ~i_clr_err);
        miss_d  = w_set_miss  | (miss_q  & ~i_clr_err);
    end

    always_comb begin
        s_axis_data_tready = (state_q != ST_HOLD);
        o_frame_ready      = (state_q == ST_HOLD);
        w_accept           = s_axis_data_tvalid & s_axis_data_tready;
        w_wr_en            = w_accept & (state_q == ST_CAPTURE);
    end

    assign o_err_early_last   = early_q;
    assign o_err_missing_last = miss_q;
    assign o_frame_count      = cnt_q;

    frame_buffer_ram #(
        .NB_DATA (CPLX_PARTS*NB_INPUT),
        .NB_ADDR (NB_COUNT),
        .DEPTH   (N_POINT)
    ) u_frame_buffer_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (idx_q),
        .i_wr_data (s_axis_data_tdata),
        .i_rd_en   (i_rd_en),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

endmodule
`default_nettype wire
